// File: rtl/spi_reg_pkg.sv
`timescale 1ns/1ps
// spi_reg_pkg: shared types and helpers for the SPI register burst port.
// Contents: FSM state enum, header field offsets, SPI mode edge selection.
// No ports; imported by spi_reg_burst.
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, HDR, WR, RD} spi_state_t;

  // Header field positions, counted down from the header MSB.
  localparam int HDR_RW_OFS   = 1;
  localparam int HDR_INCR_OFS = 2;

  // MOSI is sampled on the rising SPI edge when CPOL and CPHA agree,
  // otherwise on the falling edge; MISO changes on the opposite edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// spi_sync_edge: two-flop synchroniser for an asynchronous SPI pin with
// single-cycle rise/fall pulses derived from the synchronised level.
// Ports: clk/rst (async, active-high), din (async pin), rise/fall (pulses).
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/spi_reg_burst.sv
`timescale 1ns/1ps
// spi_reg_burst: SPI target register port, all four SPI modes, multi-word
// bursts with optional address auto-increment inside one chip-select frame.
// Ports: SPI pins (spi_clk/spi_cs_n/spi_mosi in, spi_miso out), cpol/cpha,
//   status word, register-file side (reg_addr, reg_wr_en/reg_wr_data,
//   reg_rd_req/reg_rd_data), busy and frame_err flags.
module spi_reg_burst
  import spi_reg_pkg::*;
#(
  parameter  int ADDR_W = 6,
  parameter  int DATA_W = 8,
  localparam int HDR_W  = ADDR_W + 2,
  localparam int STAT_W = HDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [STAT_W-1:0] status,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              reg_rd_req,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              busy,
  output logic              frame_err
);

  localparam int TX_W  = imax(HDR_W, DATA_W);
  localparam int CNT_W = $clog2(TX_W);

  logic clk_rise, clk_fall, cs_rise, cs_fall;

  // Both syncs reset to 0 so a chip select already low at reset release
  // produces no falling edge: the frame must be re-armed by a cs_n rise.
  spi_sync_edge #(.RST_VAL(1'b0)) u_clk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_clk),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI goes through the same two-flop depth as spi_clk, so the level seen
  // on an edge pulse is the level present at that SPI edge.
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  spi_state_t        state;
  logic              armed;
  logic              mode_rise;
  logic              need_load;
  logic              incr_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [TX_W-2:0]   rx_sr;
  logic [TX_W-1:0]   tx_sr;
  logic [DATA_W-1:0] rd_hold;
  logic              rd_cap;

  logic              sof, eof, samp, chg;
  logic              last_hdr_bit, last_data_bit;
  logic [HDR_W-1:0]  hdr_word;
  logic [DATA_W-1:0] data_word;
  logic [TX_W-1:0]   stat_word, rd_word;

  assign sof  = (state == IDLE) && armed && cs_fall;
  assign eof  = (state != IDLE) && cs_rise;
  // End of frame takes priority over a coincident clock edge.
  assign samp = (state != IDLE) && !eof && (mode_rise ? clk_rise : clk_fall);
  assign chg  = (state != IDLE) && !eof && (mode_rise ? clk_fall : clk_rise);

  assign last_hdr_bit  = (bit_cnt == CNT_W'(HDR_W - 1));
  assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign hdr_word      = {rx_sr[HDR_W-2:0], mosi_s2};
  assign data_word     = {rx_sr[DATA_W-2:0], mosi_s2};

  // Outgoing words are MSB-aligned in the shared tx shift register.
  assign stat_word = TX_W'(status) << (TX_W - STAT_W);
  assign rd_word   = TX_W'(rd_hold) << (TX_W - DATA_W);
  assign spi_miso  = tx_sr[TX_W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      armed       <= 1'b0;
      mode_rise   <= 1'b0;
      need_load   <= 1'b0;
      incr_q      <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_req  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_req <= 1'b0;
      frame_err  <= 1'b0;

      if (cs_rise) armed <= 1'b1;

      // Address advances once the strobe for the current word has gone out.
      if (reg_wr_en || reg_rd_req) reg_addr <= reg_addr + ADDR_W'(incr_q);

      if (eof) begin
        state     <= IDLE;
        busy      <= 1'b0;
        frame_err <= (bit_cnt != '0);
        bit_cnt   <= '0;
        tx_sr     <= '0;
        need_load <= 1'b0;
      end else if (sof) begin
        state     <= HDR;
        busy      <= 1'b1;
        mode_rise <= sample_on_rise(cpol, cpha);
        bit_cnt   <= '0;
        // CPHA=0 must present the status MSB before the first sample edge;
        // CPHA=1 loads it on the first change edge instead.
        tx_sr     <= cpha ? '0 : stat_word;
        need_load <= cpha;
      end else if (state != IDLE) begin
        if (chg) begin
          if (need_load) begin
            need_load <= 1'b0;
            tx_sr     <= (state == HDR) ? stat_word :
                         (state == RD)  ? rd_word   : '0;
          end else begin
            tx_sr <= tx_sr << 1;
          end
        end

        if (samp) begin
          rx_sr <= {rx_sr[TX_W-3:0], mosi_s2};
          if (state == HDR && last_hdr_bit) begin
            bit_cnt    <= '0;
            need_load  <= 1'b1;
            reg_addr   <= hdr_word[ADDR_W-1:0];
            incr_q     <= hdr_word[HDR_W-HDR_INCR_OFS];
            state      <= hdr_word[HDR_W-HDR_RW_OFS] ? WR : RD;
            reg_rd_req <= !hdr_word[HDR_W-HDR_RW_OFS];
          end else if (state != HDR && last_data_bit) begin
            bit_cnt   <= '0;
            need_load <= 1'b1;
            if (state == WR) begin
              reg_wr_data <= data_word;
              reg_wr_en   <= 1'b1;
            end else begin
              // Prefetch for the next word; dropped silently if the frame ends.
              reg_rd_req <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  // Read data arrives one cycle after the request; hold it for the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cap  <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_cap <= reg_rd_req;
      if (rd_cap) rd_hold <= reg_rd_data;
    end
  end

endmodule

// File: doc/spi_reg_burst.md
Name: spi_reg_burst

Overview:
SPI target register port, the next generation of the single-word SPI register interface. Generalises data/address width, supports all four SPI modes (CPOL/CPHA) and multi-word bursts with optional address auto-increment in one chip-select frame. Sits between the chip-level SPI pins and the register file; system-clock domain only, with SPI inputs oversampled.

Parameters:
ADDR_W, 6, register address width; header width HDR_W = ADDR_W+2
DATA_W, 8, register data width, ≥4
STAT_W, derived = HDR_W, width of status word shifted out during header

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
spi_clk  in  1  SPI clock (async)
spi_cs_n  in  1  chip select, active-low (async)
spi_mosi  in  1  serial data in (async)
spi_miso  out  1  serial data out
cpol  in  1  clock polarity, sampled at frame start
cpha  in  1  clock phase, sampled at frame start
status  in  STAT_W  status word returned during header
reg_addr  out  ADDR_W  current register address
reg_wr_en  out  1  one-cycle write strobe
reg_wr_data  out  DATA_W  write data, valid with reg_wr_en
reg_rd_req  out  1  one-cycle read request at reg_addr
reg_rd_data  in  DATA_W  read data, valid exactly 1 clk after reg_rd_req
busy  out  1  frame in progress
frame_err  out  1  one-cycle pulse: frame ended mid-word

Behaviour:
- One clock, clk; rst asynchronous active-high. Reset: spi_miso=0, reg_addr=0, reg_wr_en=0, reg_wr_data=0, reg_rd_req=0, busy=0, frame_err=0, FSM=IDLE.
- Inputs double-flop synchronised; edge pulses derived from synced values. Requirement: spi_clk ≤ clk/8.
- Sample edge = rising if cpol==cpha, else falling; change edge = the other. cpol/cpha latched on cs_n fall, held for frame.
- Header (HDR_W bits, MSB first): bit HDR_W-1 = rw (1 write, 0 read), bit HDR_W-2 = incr, [ADDR_W-1:0] = address.
- FSM: IDLE -> HDR on cs_n fall; HDR -> WR or RD after HDR_W sample edges; WR/RD loop per DATA_W-bit word; any state -> IDLE on cs_n rise (EOF).
- busy=1 from cycle after cs_n fall to cycle after cs_n rise.
- MISO: tx shift register, spi_miso = MSB. Word load: CPHA=0 at cs_n fall (status) and at first change edge after a word's last sample; CPHA=1 at first change edge of each word. Other change edges shift left, fill 0. WR data phase: miso drives 0.
- Header end: reg_addr <= header address on same cycle as last header sample registered.
- Read: reg_rd_req pulses cycle after header completes (reg_addr valid), and cycle after each completed read word (prefetch). reg_rd_data captured next clk into hold reg, loaded per MISO rule. Prefetch unused at EOF: discarded, no side effect.
- Write: after each DATA_W-th sample, reg_wr_data <= rx word, reg_wr_en pulses 1 cycle.
- Increment: after each word's rd_req/wr_en, reg_addr += incr; wraps 2^ADDR_W-1 -> 0. incr=0: same address repeated.
- EOF mid-header or mid-word: partial bits discarded, no strobe, frame_err pulses 1 cycle; counters cleared. EOF on exact word boundary: no error.
- EOF and sample edge in same cycle: EOF wins; that bit ignored.
- cs_n low when rst deasserts: block stays IDLE until a full cs_n rise then fall.
- Reset mid-frame: immediate return to reset values; no strobes.

Decomposition:
- Package spi_reg_pkg: state enum (IDLE, HDR, WR, RD), header field offset constants, mode edge-select helper function.
- Sub-module spi_sync_edge: 2-FF synchroniser + rise/fall pulse outputs, instantiated for spi_clk, spi_cs_n (mosi sync only).

Test Plan:
- Mode 0, write frame header 0xC5 (wr, incr, addr 5), data 0x11,0x22,0x33 -> wr_en x3 at addr 5,6,7 with 0x11,0x22,0x33; frame_err=0.
- Mode 3, read header 0x0A (rd, no incr, addr 10), 2 words, reg_rd_data=0xA5 then 0x5A -> miso header shows status, words 0xA5,0x5A; rd_req x3 (last prefetch), all addr 10.
- Mode 1 and mode 2, incr read at addr 0x3F, 2 words -> addresses 0x3F then 0x00 (wrap); miso bit-exact vs model.
- Write header 0xC0, cs_n rise after 5 data bits -> no wr_en, frame_err one pulse, busy falls.
- Async rst asserted mid-word of write burst -> all outputs 0 immediately; cs_n still low at release -> ignored until new cs_n fall, next frame correct.
- cs_n rise coincident with 8th sample edge of data word -> no wr_en, frame_err pulses.
